usb_cmd_frame_dispatcher: RTL and testbench

Receives the raw USB byte stream carrying host command frames of the form AA 55 CMD LEN_H LEN_L DATA[LEN] CHECKSUM. Validates each frame and buffers its payload. Only checksum-clean frames are released to the command handlers (DSM 0x0A, PWM 0xFE, DAC 0xFD, UART 0x07/0x08/0x09, heartbeat 0xFF), as a header handshake followed by a payload stream. Sits between the USB receive interface and the per-function handler modules.

---
 rtl/usb_cmd_pkg.sv | 44 ++++
 rtl/usb_cmd_payload_ram.sv | 33 +++
 rtl/usb_cmd_frame_dispatcher.sv | 214 +++++++++++++++++++++
 tb/tb_usb_cmd_frame_dispatcher.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cmd_pkg.sv
// ============================================================================
// Module  : usb_cmd_pkg
// Purpose : Shared command codes, frame markers, parser states and error codes
//           for the USB command frame dispatcher.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package usb_cmd_pkg;

  localparam logic [7:0] CMD_DSM       = 8'h0A;
  localparam logic [7:0] CMD_PWM       = 8'hFE;
  localparam logic [7:0] CMD_DAC       = 8'hFD;
  localparam logic [7:0] CMD_UART_CFG  = 8'h07;
  localparam logic [7:0] CMD_UART_TX   = 8'h08;
  localparam logic [7:0] CMD_UART_RX   = 8'h09;
  localparam logic [7:0] CMD_HEARTBEAT = 8'hFF;

  localparam logic [7:0] SOF1 = 8'hAA;
  localparam logic [7:0] SOF2 = 8'h55;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SOF2   = 4'd1,
    ST_CMD    = 4'd2,
    ST_LENH   = 4'd3,
    ST_LENL   = 4'd4,
    ST_DATA   = 4'd5,
    ST_CSUM   = 4'd6,
    ST_HDR    = 4'd7,
    ST_STREAM = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

endpackage

`default_nettype wire

// File: rtl/usb_cmd_payload_ram.sv
// ============================================================================
// Module  : usb_cmd_payload_ram
// Purpose : Simple dual-port byte buffer holding one frame payload;
//           synchronous write, synchronous (registered) read.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module usb_cmd_payload_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] r_mem [DEPTH];

  // rd_data holds its value while rd_en is low; the dispatcher relies on that
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/usb_cmd_frame_dispatcher.sv
// ============================================================================
// Module  : usb_cmd_frame_dispatcher
// Purpose : Parses AA 55 CMD LEN_H LEN_L DATA CSUM frames from the USB byte
//           stream and releases checksum-clean frames as header + payload.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module usb_cmd_frame_dispatcher
  import usb_cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD    = 64,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid_in,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_len,
  output logic [7:0]  pld_data,
  output logic        pld_valid,
  input  logic        pld_ready,
  output logic        pld_last,
  output logic        cmd_done,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int IW = $clog2(MAX_PAYLOAD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        r_state;
  logic [7:0]    r_sum;
  logic [IW-1:0] r_wr_idx;
  logic [IW-1:0] r_rd_idx;
  logic [TW-1:0] r_tmo;
  logic          r_q_valid;
  logic          r_q_last;

  logic [7:0]    w_ram_q;
  logic [15:0]   w_len_rx;
  logic          w_parse;
  logic          w_tmo_hit;
  logic          w_wr_en;
  logic          w_wr_last;
  logic          w_out_free;
  logic          w_q_to_out;
  logic          w_rd_en;
  logic          w_rd_last;

  assign w_len_rx   = {cmd_len[15:8], usb_data_in};
  assign w_parse    = r_state inside {ST_SOF2, ST_CMD, ST_LENH, ST_LENL, ST_DATA, ST_CSUM};
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_wr_en    = usb_data_valid_in && (r_state == ST_DATA);
  assign w_wr_last  = ((16'(r_wr_idx) + 16'd1) == cmd_len);
  assign w_rd_last  = ((16'(r_rd_idx) + 16'd1) == cmd_len);

  // Two-slot pipeline: RAM read register feeds the pld_* output register.
  // First read is launched on the header handshake itself to cut latency.
  assign w_out_free = !pld_valid || pld_ready;
  assign w_q_to_out = (r_state == ST_STREAM) && r_q_valid && w_out_free;
  assign w_rd_en    = ((r_state == ST_HDR) && cmd_valid && cmd_ready && (cmd_len != 16'd0)) ||
                      ((r_state == ST_STREAM) && (16'(r_rd_idx) < cmd_len) &&
                       (!r_q_valid || w_q_to_out));

  assign busy = (r_state != ST_IDLE);

  usb_cmd_payload_ram #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_idx[AW-1:0]),
    .wr_data (usb_data_in),
    .rd_en   (w_rd_en),
    .rd_addr (r_rd_idx[AW-1:0]),
    .rd_data (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sum     <= '0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_tmo     <= '0;
      r_q_valid <= 1'b0;
      r_q_last  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_len   <= '0;
      pld_data  <= '0;
      pld_valid <= 1'b0;
      pld_last  <= 1'b0;
      cmd_done  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      drop_cnt  <= '0;
    end else begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      cmd_done  <= 1'b0;

      if (w_rd_en) begin
        r_rd_idx  <= r_rd_idx + IW'(1);
        r_q_valid <= 1'b1;
        r_q_last  <= w_rd_last;
      end else if (w_q_to_out) begin
        r_q_valid <= 1'b0;
      end

      if (usb_data_valid_in && (r_state inside {ST_HDR, ST_STREAM}) && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;

      if (w_parse && !usb_data_valid_in && !w_tmo_hit)
        r_tmo <= r_tmo + TW'(1);
      else
        r_tmo <= '0;

      case (r_state)
        ST_IDLE: begin
          r_wr_idx  <= '0;
          r_rd_idx  <= '0;
          r_q_valid <= 1'b0;
          if (usb_data_valid_in && (usb_data_in == SOF1)) r_state <= ST_SOF2;
        end
        ST_SOF2: if (usb_data_valid_in) begin
          if (usb_data_in == SOF2)      r_state <= ST_CMD;
          else if (usb_data_in != SOF1) r_state <= ST_IDLE;
        end
        ST_CMD: if (usb_data_valid_in) begin
          cmd_code <= usb_data_in;
          r_sum    <= usb_data_in;
          r_state  <= ST_LENH;
        end
        ST_LENH: if (usb_data_valid_in) begin
          cmd_len[15:8] <= usb_data_in;
          r_sum         <= r_sum + usb_data_in;
          r_state       <= ST_LENL;
        end
        ST_LENL: if (usb_data_valid_in) begin
          cmd_len[7:0] <= usb_data_in;
          r_sum        <= r_sum + usb_data_in;
          if (w_len_rx > 16'(MAX_PAYLOAD)) begin
            err_valid <= 1'b1;
            err_code  <= ERR_LEN;
            r_state   <= ST_IDLE;
          end else if (w_len_rx == 16'd0) begin
            r_state <= ST_CSUM;
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: if (usb_data_valid_in) begin
          r_sum    <= r_sum + usb_data_in;
          r_wr_idx <= r_wr_idx + IW'(1);
          if (w_wr_last) r_state <= ST_CSUM;
        end
        ST_CSUM: if (usb_data_valid_in) begin
          if (usb_data_in == r_sum) begin
            cmd_valid <= 1'b1;
            r_state   <= ST_HDR;
          end else begin
            err_valid <= 1'b1;
            err_code  <= ERR_CSUM;
            r_state   <= ST_IDLE;
          end
        end
        ST_HDR: if (cmd_ready) begin
          cmd_valid <= 1'b0;
          if (cmd_len == 16'd0) begin
            cmd_done <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_q_to_out) begin
            pld_valid <= 1'b1;
            pld_data  <= w_ram_q;
            pld_last  <= r_q_last;
          end else if (pld_valid && pld_ready) begin
            pld_valid <= 1'b0;
            pld_last  <= 1'b0;
            if (pld_last) begin
              cmd_done <= 1'b1;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // An idle gap inside a frame abandons it; no byte arrives this cycle.
      if (w_parse && !usb_data_valid_in && w_tmo_hit) begin
        err_valid <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        r_state   <= ST_IDLE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_cmd_frame_dispatcher.sv
// ============================================================================
// Module  : tb_usb_cmd_frame_dispatcher
// Purpose : Directed self-checking bench for usb_cmd_frame_dispatcher.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_usb_cmd_frame_dispatcher;

  localparam int MAXP = 64;
  localparam int TMO  = 60000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  usb_data_in = '0;
  logic        usb_data_valid_in = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_len;
  logic [7:0]  pld_data;
  logic        pld_valid;
  logic        pld_ready = 1'b0;
  logic        pld_last;
  logic        cmd_done;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        busy;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  usb_cmd_frame_dispatcher #(
    .MAX_PAYLOAD    (MAXP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .usb_data_in       (usb_data_in),
    .usb_data_valid_in (usb_data_valid_in),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_code          (cmd_code),
    .cmd_len           (cmd_len),
    .pld_data          (pld_data),
    .pld_valid         (pld_valid),
    .pld_ready         (pld_ready),
    .pld_last          (pld_last),
    .cmd_done          (cmd_done),
    .err_valid         (err_valid),
    .err_code          (err_code),
    .busy              (busy),
    .drop_cnt          (drop_cnt)
  );

  int checks = 0;
  int failures = 0;

  int edge_n = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int pld_seen = 0;
  int hold_viol = 0;
  int hs_edge = -1;
  int first_pld_edge = -1;
  logic [7:0] got_data[$];
  logic       got_last[$];
  int         got_edge[$];
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] fr[$];

  // Observe pre-edge values of DUT outputs on every rising edge
  always @(posedge clk) begin
    edge_n++;
    if (cmd_done) done_cnt++;
    if (err_valid) err_cnt++;
    if (cmd_done && err_valid) overlap_cnt++;
    if (pld_valid) begin
      pld_seen++;
      if (first_pld_edge < 0) first_pld_edge = edge_n;
    end
    if (cmd_valid && cmd_ready) hs_edge = edge_n;
    if (prev_stall && (!pld_valid || pld_data !== prev_data || pld_last !== prev_last)) hold_viol++;
    prev_stall = pld_valid && !pld_ready;
    prev_data  = pld_data;
    prev_last  = pld_last;
    if (pld_valid && pld_ready) begin
      got_data.push_back(pld_data);
      got_last.push_back(pld_last);
      got_edge.push_back(edge_n);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    usb_data_in = b;
    usb_data_valid_in = 1'b1;
    @(posedge clk);
    #1;
    usb_data_valid_in = 1'b0;
  endtask

  task automatic send_fr();
    foreach (fr[i]) send(fr[i]);
  endtask

  // Accept the header on the first cycle, then serve payload until cmd_done
  task automatic serve(input int budget, input bit toggle);
    int d0;
    d0 = done_cnt;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cmd_ready = (c == 0);
      pld_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (done_cnt != d0) break;
    end
    cmd_ready = 1'b0;
    pld_ready = 1'b0;
  endtask

  task automatic clear_caps();
    got_data.delete();
    got_last.delete();
    got_edge.delete();
  endtask

  initial begin
    int d0;
    int e0;
    int n;
    int lat;
    logic [4:0] lastmask;
    logic [7:0] pwm_exp[5];
    pwm_exp[0] = 8'h00; pwm_exp[1] = 8'h03; pwm_exp[2] = 8'hE8;
    pwm_exp[3] = 8'h01; pwm_exp[4] = 8'hF4;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {cmd_valid, pld_valid, pld_last, cmd_done, err_valid, busy}, 64'd0);
    check("reset_data", {cmd_code, cmd_len, pld_data, err_code, drop_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Heartbeat, zero-length frame
    fr = {8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
    send_fr();
    check("hb_hdr", {cmd_valid, busy, cmd_code, cmd_len}, {1'b1, 1'b1, 8'hFF, 16'h0000});
    @(negedge clk);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    check("hb_done_pulse", {cmd_done, cmd_valid}, {1'b1, 1'b0});
    @(posedge clk);
    #1;
    check("hb_done_end", {cmd_done, busy}, {1'b0, 1'b0});
    check("hb_no_pld", pld_seen, 0);

    // PWM frame with pld_ready toggling 1010
    clear_caps();
    first_pld_edge = -1;
    fr = {8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h00, 8'h03, 8'hE8, 8'h01, 8'hF4, 8'hE3};
    send_fr();
    check("pwm_hdr", {cmd_valid, cmd_code, cmd_len}, {1'b1, 8'hFE, 16'h0005});
    d0 = done_cnt;
    serve(60, 1'b1);
    check("pwm_count", got_data.size(), 5);
    lastmask = '0;
    for (int i = 0; i < got_data.size() && i < 5; i++) begin
      check($sformatf("pwm_byte%0d", i), got_data[i], pwm_exp[i]);
      lastmask[i] = got_last[i];
    end
    check("pwm_last", lastmask, 5'b10000);
    check("pwm_done_once", done_cnt - d0, 1);
    check("pwm_hold", hold_viol, 0);
    // pld_valid is registered one edge before the monitor sees it
    lat = first_pld_edge - hs_edge - 1;
    check("pwm_latency", (lat >= 0 && lat <= 2), 1'b1);
    check("pwm_idle", busy, 1'b0);

    // Bad checksum, then recovery with a heartbeat
    fr = {8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h00, 8'h03, 8'hE8, 8'h01, 8'hF4, 8'hE4};
    send_fr();
    check("csum_err", {err_valid, err_code, cmd_valid}, {1'b1, 2'd1, 1'b0});
    @(posedge clk);
    #1;
    check("csum_err_end", {err_valid, busy, cmd_valid}, {1'b0, 1'b0, 1'b0});
    fr = {8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
    send_fr();
    check("recov_hdr", {cmd_valid, cmd_code, cmd_len}, {1'b1, 8'hFF, 16'h0000});
    d0 = done_cnt;
    serve(10, 1'b0);
    check("recov_done", done_cnt - d0, 1);

    // Same PWM frame with pld_ready held high: one byte per cycle
    clear_caps();
    fr = {8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h00, 8'h03, 8'hE8, 8'h01, 8'hF4, 8'hE3};
    send_fr();
    serve(40, 1'b0);
    check("tput_count", got_data.size(), 5);
    if (got_data.size() == 5) begin
      check("tput_span", got_edge[4] - got_edge[0], 4);
      check("tput_lastbyte", {got_data[4], got_last[4]}, {8'hF4, 1'b1});
    end

    // Length overflow
    fr = {8'hAA, 8'h55, 8'h08, 8'h01, 8'h00};
    send_fr();
    check("len_err", {err_valid, err_code, busy}, {1'b1, 2'd2, 1'b0});
    @(posedge clk);
    #1;
    e0 = err_cnt;
    fr = {8'h11, 8'h22, 8'h33, 8'h00, 8'h55};
    send_fr();
    @(posedge clk);
    #1;
    check("len_ignore", {err_cnt - e0, 31'd0, busy, cmd_valid}, {32'd0, 31'd0, 1'b0, 1'b0});

    // Timeout mid-DATA
    fr = {8'hAA, 8'h55, 8'h0A, 8'h00, 8'h01};
    send_fr();
    n = 0;
    while (n < TMO + 10) begin
      @(posedge clk);
      #1;
      n++;
      if (err_valid) break;
    end
    check("tmo_err", {err_valid, err_code, busy}, {1'b1, 2'd3, 1'b0});
    check("tmo_latency", (n >= TMO && n <= TMO + 1), 1'b1);

    // Resync through a doubled AA
    clear_caps();
    fr = {8'hAA, 8'hAA, 8'h55, 8'h0A, 8'h00, 8'h01, 8'h0F, 8'h1A};
    send_fr();
    check("resync_hdr", {cmd_valid, cmd_code, cmd_len}, {1'b1, 8'h0A, 16'h0001});
    serve(20, 1'b0);
    check("resync_count", got_data.size(), 1);
    if (got_data.size() == 1) check("resync_byte", {got_data[0], got_last[0]}, {8'h0F, 1'b1});

    // Bytes arriving while the header waits are dropped
    fr = {8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
    send_fr();
    fr = {8'h12, 8'h34, 8'h56};
    send_fr();
    check("drop_cnt", drop_cnt, 16'd3);
    check("drop_hdr_stable", {cmd_valid, cmd_code, cmd_len}, {1'b1, 8'hFF, 16'h0000});
    d0 = done_cnt;
    serve(10, 1'b0);
    check("drop_done", done_cnt - d0, 1);

    // Reset asserted mid-DATA
    fr = {8'hAA, 8'h55, 8'hFE, 8'h00, 8'h05, 8'h00, 8'h03};
    send_fr();
    check("mid_busy", busy, 1'b1);
    e0 = err_cnt;
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", {cmd_valid, pld_valid, pld_last, cmd_done, err_valid, busy}, 64'd0);
    check("rst_data", {cmd_code, cmd_len, pld_data, err_code, drop_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_pulse", {err_cnt - e0, done_cnt - d0}, 64'd0);
    fr = {8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
    send_fr();
    check("post_rst_hdr", {cmd_valid, cmd_code}, {1'b1, 8'hFF});
    serve(10, 1'b0);

    check("no_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
